cfg_ram_arb: RTL

- Two-port arbiter and sequencer for the 512-byte single-port config RAM that backs $D600-$D7FF.
- Port A (bus) is the A8 bus monitor. It has hard timing deadlines and absolute priority.
- Port B (engine) is the internal aperture/SDRAM engine. It uses a req/ack handshake and is stalled whenever the bus port requests.
- The block also tracks which of the 16 memory-aperture descriptors the A8 has rewritten, so the engine knows which page-map updates to issue.

---
 rtl/cfg_ram_arb_if.sv | 34 +++
 rtl/cfg_ram_arb.sv | 128 ++++++++++++
 2 files changed

// File: rtl/cfg_ram_arb_if.sv
// Request/response signals of the two config-RAM clients: the A8 bus monitor
// and the aperture/SDRAM engine. The master side is the clients, the slave side is the arbiter.
interface cfg_ram_arb_if #(
  parameter int ADDR_BITS = 9
);
  logic                 bus_req;
  logic                 bus_we;
  logic [ADDR_BITS-1:0] bus_addr;
  logic [7:0]           bus_wdata;
  logic                 bus_rvalid;
  logic [7:0]           bus_rdata;

  logic                 eng_req;
  logic                 eng_we;
  logic [ADDR_BITS-1:0] eng_addr;
  logic [7:0]           eng_wdata;
  logic                 eng_ack;
  logic                 eng_rvalid;
  logic [7:0]           eng_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rvalid, bus_rdata,
    output eng_req, eng_we, eng_addr, eng_wdata,
    input  eng_ack, eng_rvalid, eng_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rvalid, bus_rdata,
    input  eng_req, eng_we, eng_addr, eng_wdata,
    output eng_ack, eng_rvalid, eng_rdata
  );
endinterface

// File: rtl/cfg_ram_arb.sv
// Fixed-priority arbiter for the $D600-$D7FF config RAM. The bus monitor always wins.
// Reads are tagged down a pipeline so that each result returns to the port that issued it.
module cfg_ram_arb #(
  parameter int ADDR_BITS = 9,
  parameter int RAM_LAT   = 1,
  parameter int N_AP      = 16
) (
  input  logic                 clk200,
  input  logic                 a8_rst_n,
  cfg_ram_arb_if.slave         cif,
  output logic [N_AP-1:0]      ap_dirty,
  input  logic [N_AP-1:0]      ap_dirty_clr,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_we,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata
);

  // Reset asserts at once but is released only on a clk200 edge.
  logic [1:0] rst_sync_reg;
  logic       rst_n_int;

  always_ff @(posedge clk200 or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_reg[1];

  logic                 bus_grant;
  logic                 eng_grant;
  logic                 eng_ack_reg;
  logic [ADDR_BITS-1:0] ram_addr_reg, ram_addr_next;
  logic                 ram_we_reg, ram_we_next;
  logic [7:0]           ram_wdata_reg, ram_wdata_next;
  logic [RAM_LAT:0]     tag_valid_reg, tag_valid_next;
  logic [RAM_LAT:0]     tag_port_reg, tag_port_next;
  logic                 bus_rvalid_reg, eng_rvalid_reg;
  logic [7:0]           bus_rdata_reg, eng_rdata_reg;
  logic [N_AP-1:0]      ap_dirty_reg, ap_dirty_next, ap_set;
  logic                 flag_write;

  // An engine request seen in its own ack cycle is the next request. It waits one cycle.
  assign bus_grant = cif.bus_req;
  assign eng_grant = !cif.bus_req && cif.eng_req && !eng_ack_reg;

  always_comb begin
    ram_addr_next  = ram_addr_reg;
    ram_we_next    = 1'b0;
    ram_wdata_next = ram_wdata_reg;
    if (bus_grant) begin
      ram_addr_next  = cif.bus_addr;
      ram_we_next    = cif.bus_we;
      ram_wdata_next = cif.bus_wdata;
    end else if (eng_grant) begin
      ram_addr_next  = cif.eng_addr;
      ram_we_next    = cif.eng_we;
      ram_wdata_next = cif.eng_wdata;
    end
  end

  // Owner tag: port 0 = bus, 1 = engine. It reaches the last stage when ram_rdata is valid.
  assign tag_valid_next[0] = (bus_grant && !cif.bus_we) || (eng_grant && !cif.eng_we);
  assign tag_port_next[0]  = eng_grant;

  for (genvar gi = 1; gi <= RAM_LAT; gi++) begin : g_tag
    assign tag_valid_next[gi] = tag_valid_reg[gi-1];
    assign tag_port_next[gi]  = tag_port_reg[gi-1];
  end

  // Byte $xF of each 16-byte descriptor on page $D6 holds the aperture flags.
  assign flag_write = bus_grant && cif.bus_we && !cif.bus_addr[ADDR_BITS-1]
                      && (cif.bus_addr[3:0] == 4'hF);

  for (genvar gi = 0; gi < N_AP; gi++) begin : g_dirty
    assign ap_set[gi]        = flag_write && (cif.bus_addr[7:4] == 4'(gi));
    assign ap_dirty_next[gi] = ap_set[gi] | (ap_dirty_reg[gi] & ~ap_dirty_clr[gi]);
  end

  always_ff @(posedge clk200 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      ram_addr_reg   <= '0;
      ram_we_reg     <= 1'b0;
      ram_wdata_reg  <= '0;
      eng_ack_reg    <= 1'b0;
      tag_valid_reg  <= '0;
      tag_port_reg   <= '0;
      bus_rvalid_reg <= 1'b0;
      bus_rdata_reg  <= '0;
      eng_rvalid_reg <= 1'b0;
      eng_rdata_reg  <= '0;
      ap_dirty_reg   <= '0;
    end else begin
      ram_addr_reg   <= ram_addr_next;
      ram_we_reg     <= ram_we_next;
      ram_wdata_reg  <= ram_wdata_next;
      eng_ack_reg    <= eng_grant;
      tag_valid_reg  <= tag_valid_next;
      tag_port_reg   <= tag_port_next;
      ap_dirty_reg   <= ap_dirty_next;
      bus_rvalid_reg <= 1'b0;
      eng_rvalid_reg <= 1'b0;
      if (tag_valid_reg[RAM_LAT]) begin
        if (tag_port_reg[RAM_LAT]) begin
          eng_rvalid_reg <= 1'b1;
          eng_rdata_reg  <= ram_rdata;
        end else begin
          bus_rvalid_reg <= 1'b1;
          bus_rdata_reg  <= ram_rdata;
        end
      end
    end
  end

  assign ram_addr       = ram_addr_reg;
  assign ram_we         = ram_we_reg;
  assign ram_wdata      = ram_wdata_reg;
  assign ap_dirty       = ap_dirty_reg;
  assign cif.eng_ack    = eng_ack_reg;
  assign cif.bus_rvalid = bus_rvalid_reg;
  assign cif.bus_rdata  = bus_rdata_reg;
  assign cif.eng_rvalid = eng_rvalid_reg;
  assign cif.eng_rdata  = eng_rdata_reg;

endmodule
